// File: rtl/imm_extend_pipe.sv
// Pipelined immediate extender: zero/sign/upper/branch widening of an IN_W-bit
// immediate, carried through DEPTH elastic valid/ready stages with flush.
module imm_extend_pipe #(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_imm
);

    localparam int unsigned EXT_W = OUT_W - IN_W;

    if (OUT_W < IN_W + 2 || DEPTH < 1 || DEPTH > 4) begin : g_param_check
        $error("imm_extend_pipe: illegal parameter combination");
    end

    logic [OUT_W-1:0] data [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [DEPTH-1:0] adv;
    logic [OUT_W-1:0] sext;
    logic [OUT_W-1:0] ext;
    logic             accept;

    // Extension of the raw immediate according to the requested mode
    always_comb begin
        sext = {{EXT_W{in_imm[IN_W-1]}}, in_imm};
        case (in_mode)
            2'b00:   ext = {{EXT_W{1'b0}}, in_imm};
            2'b01:   ext = sext;
            2'b10:   ext = {in_imm, {EXT_W{1'b0}}};
            default: ext = {sext[OUT_W-3:0], 2'b00};
        endcase
    end

    // A stage may load when it, or any stage downstream of it, has a hole,
    // or when the output is being taken; this collapses bubbles.
    always_comb begin
        adv = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            adv[k] = out_ready;
            for (int unsigned j = k; j < DEPTH; j++) begin
                if (!valid[j]) begin
                    adv[k] = 1'b1;
                end
            end
        end
    end

    assign in_ready  = !reset && !flush && adv[0];
    assign accept    = in_valid && in_ready;
    assign out_valid = valid[DEPTH-1];
    assign out_imm   = data[DEPTH-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= '0;
            for (int unsigned k = 0; k < DEPTH; k++) begin
                data[k] <= '0;
            end
        end else if (flush) begin
            valid <= '0;
        end else begin
            if (adv[0]) begin
                valid[0] <= accept;
                if (accept) begin
                    data[0] <= ext;
                end
            end
            for (int unsigned k = 1; k < DEPTH; k++) begin
                if (adv[k]) begin
                    valid[k] <= valid[k-1];
                    if (valid[k-1]) begin
                        data[k] <= data[k-1];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Bench for imm_extend_pipe: DEPTH=2 main instance plus DEPTH=1 and DEPTH=4
// instances, with a tagged scoreboard checking order, value and latency.
module tb_imm_extend_pipe;

    logic        clk = 1'b0;
    logic [2:0]  rst;
    logic [2:0]  in_valid;
    logic [2:0]  in_ready;
    logic [2:0]  flush;
    logic [2:0]  out_valid;
    logic [2:0]  out_ready;
    logic [15:0] in_imm  [3];
    logic [1:0]  in_mode [3];
    logic [31:0] out_imm [3];

    typedef struct {
        int          d;
        logic [31:0] v;
        int          acc;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   out_cnt [3];
    bit   chk_lat  = 1'b0;
    int   idx_m;
    int   lat_m;

    logic [31:0] mode_exp [4];
    logic [15:0] bnd_imm  [3];
    logic [1:0]  bnd_mode [3];
    logic [31:0] bnd_exp  [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    imm_extend_pipe #(.IN_W(16), .OUT_W(32), .DEPTH(2)) u_d2 (
        .clk(clk), .reset(rst[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_imm(in_imm[0]), .in_mode(in_mode[0]), .flush(flush[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_imm(out_imm[0]));

    imm_extend_pipe #(.IN_W(16), .OUT_W(32), .DEPTH(1)) u_d1 (
        .clk(clk), .reset(rst[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_imm(in_imm[1]), .in_mode(in_mode[1]), .flush(flush[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_imm(out_imm[1]));

    imm_extend_pipe #(.IN_W(16), .OUT_W(32), .DEPTH(4)) u_d4 (
        .clk(clk), .reset(rst[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_imm(in_imm[2]), .in_mode(in_mode[2]), .flush(flush[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_imm(out_imm[2]));

    function automatic int depth_of(input int d);
        case (d)
            0:       return 2;
            1:       return 1;
            default: return 4;
        endcase
    endfunction

    function automatic logic [31:0] model(input logic [15:0] imm, input logic [1:0] m);
        logic [31:0] s;
        s = 32'($signed(imm));
        case (m)
            2'd0:    return 32'(imm);
            2'd1:    return s;
            2'd2:    return 32'(imm) << 16;
            default: return s << 2;
        endcase
    endfunction

    // Scoreboard: push on input handshake, pop and compare on output handshake
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (rst[d]) begin
                for (int i = sbq.size() - 1; i >= 0; i--)
                    if (sbq[i].d == d) sbq.delete(i);
            end else begin
                if (out_valid[d] && out_ready[d]) begin
                    idx_m = -1;
                    for (int i = 0; i < sbq.size(); i++)
                        if (idx_m < 0 && sbq[i].d == d) idx_m = i;
                    n_checks++;
                    if (idx_m < 0) begin
                        n_fail++;
                        $display("FAIL sb_unexpected dut%0d got %h expected no output", d, out_imm[d]);
                    end else begin
                        if (out_imm[d] !== sbq[idx_m].v) begin
                            n_fail++;
                            $display("FAIL sb_data dut%0d got %h expected %h", d, out_imm[d], sbq[idx_m].v);
                        end
                        if (chk_lat) begin
                            lat_m = cyc - sbq[idx_m].acc;
                            n_checks++;
                            if (lat_m != depth_of(d)) begin
                                n_fail++;
                                $display("FAIL sb_latency dut%0d got %0d expected %0d", d, lat_m, depth_of(d));
                            end
                        end
                        sbq.delete(idx_m);
                        out_cnt[d]++;
                    end
                end
                if (flush[d]) begin
                    for (int i = sbq.size() - 1; i >= 0; i--)
                        if (sbq[i].d == d) sbq.delete(i);
                end else if (in_valid[d] && in_ready[d]) begin
                    sbq.push_back('{d: d, v: model(in_imm[d], in_mode[d]), acc: cyc});
                end
            end
        end
    end

    // Present one immediate and hold it until accepted; returns just after the capture edge
    task automatic send(input int d, input logic [15:0] imm, input logic [1:0] m);
        bit ok;
        ok = 1'b0;
        in_valid[d] = 1'b1;
        in_imm[d]   = imm;
        in_mode[d]  = m;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            if (in_ready[d]) ok = 1'b1;
        end
        @(posedge clk); #1;
        in_valid[d] = 1'b0;
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout dut%0d got no in_ready expected acceptance", d);
        end
    endtask

    task automatic test_reset();
        rst = 3'b111; in_valid = '0; flush = '0; out_ready = 3'b111;
        for (int d = 0; d < 3; d++) begin
            in_imm[d] = '0; in_mode[d] = '0; out_cnt[d] = 0;
        end
        @(negedge clk);
        n_checks++;
        if (out_valid !== 3'b000) begin
            n_fail++; $display("FAIL reset_out_valid got %b expected 000", out_valid);
        end
        n_checks++;
        if (out_imm[0] !== 32'h0) begin
            n_fail++; $display("FAIL reset_out_imm got %h expected 00000000", out_imm[0]);
        end
        n_checks++;
        if (in_ready !== 3'b000) begin
            n_fail++; $display("FAIL reset_in_ready got %b expected 000", in_ready);
        end
        @(posedge clk); #1;
        rst = 3'b000;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 3'b111) begin
            n_fail++; $display("FAIL post_reset_in_ready got %b expected 111", in_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_modes();
        int k;
        chk_lat = 1'b1;
        for (int m = 0; m < 4; m++) begin
            send(0, 16'h8001, 2'(m));
            k = 0;
            for (int n = 1; n <= 10 && k == 0; n++) begin
                @(negedge clk);
                if (out_valid[0]) k = n;
            end
            n_checks++;
            if (k != 2) begin
                n_fail++; $display("FAIL mode%0d_latency got %0d expected 2", m, k);
            end
            n_checks++;
            if (out_imm[0] !== mode_exp[m]) begin
                n_fail++; $display("FAIL mode%0d_value got %h expected %h", m, out_imm[0], mode_exp[m]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_boundaries();
        int k;
        chk_lat = 1'b1;
        for (int b = 0; b < 3; b++) begin
            send(0, bnd_imm[b], bnd_mode[b]);
            k = 0;
            for (int n = 1; n <= 10 && k == 0; n++) begin
                @(negedge clk);
                if (out_valid[0]) k = n;
            end
            n_checks++;
            if (k == 0 || out_imm[0] !== bnd_exp[b]) begin
                n_fail++; $display("FAIL boundary%0d got %h expected %h", b, out_imm[0], bnd_exp[b]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        int          nxt;
        int          occ;
        bit          acc;
        bit          del;
        logic [31:0] got[$];
        nxt = 1; occ = 0;
        chk_lat = 1'b0;
        for (int c = 1; c <= 25; c++) begin
            in_valid[0]  = (nxt <= 5);
            in_imm[0]    = 16'(nxt);
            in_mode[0]   = 2'd0;
            out_ready[0] = !(c >= 3 && c <= 6);
            @(negedge clk);
            n_checks++;
            if (in_ready[0] !== (occ < 2 || out_ready[0])) begin
                n_fail++;
                $display("FAIL bp_in_ready c%0d got %b expected %b", c, in_ready[0], (occ < 2 || out_ready[0]));
            end
            if (!out_ready[0]) begin
                n_checks++;
                if (out_valid[0] !== 1'b1 || out_imm[0] !== 32'h1) begin
                    n_fail++;
                    $display("FAIL bp_hold c%0d got %b/%h expected 1/00000001", c, out_valid[0], out_imm[0]);
                end
            end
            acc = in_valid[0] && in_ready[0];
            del = out_valid[0] && out_ready[0];
            if (del) got.push_back(out_imm[0]);
            if (acc) nxt++;
            occ = occ + int'(acc) - int'(del);
            @(posedge clk); #1;
        end
        in_valid[0] = 1'b0;
        out_ready[0] = 1'b1;
        n_checks++;
        if (got.size() != 5) begin
            n_fail++; $display("FAIL bp_count got %0d expected 5", got.size());
        end
        for (int i = 0; i < got.size() && i < 5; i++) begin
            n_checks++;
            if (got[i] !== 32'(i + 1)) begin
                n_fail++; $display("FAIL bp_order%0d got %h expected %h", i, got[i], 32'(i + 1));
            end
        end
    endtask

    task automatic test_flush();
        int k;
        chk_lat = 1'b0;
        out_ready[0] = 1'b0;
        send(0, 16'h0011, 2'd0);
        send(0, 16'h0022, 2'd0);
        flush[0] = 1'b1; in_valid[0] = 1'b1; in_imm[0] = 16'hAAAA; in_mode[0] = 2'd0;
        @(negedge clk);
        n_checks++;
        if (in_ready[0] !== 1'b0) begin
            n_fail++; $display("FAIL flush_in_ready got %b expected 0", in_ready[0]);
        end
        @(posedge clk); #1;
        flush[0] = 1'b0; in_valid[0] = 1'b0; out_ready[0] = 1'b1;
        @(negedge clk);
        n_checks++;
        if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_after got valid=%b ready=%b expected valid=0 ready=1", out_valid[0], in_ready[0]);
        end
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid[0] !== 1'b0) begin
                n_fail++; $display("FAIL flush_leak got out_valid=%b out_imm=%h expected 0", out_valid[0], out_imm[0]);
            end
        end
        @(posedge clk); #1;
        chk_lat = 1'b1;
        send(0, 16'h1234, 2'd0);
        k = 0;
        for (int n = 1; n <= 10 && k == 0; n++) begin
            @(negedge clk);
            if (out_valid[0]) k = n;
        end
        n_checks++;
        if (k != 2 || out_imm[0] !== 32'h00001234) begin
            n_fail++; $display("FAIL flush_next got lat=%0d val=%h expected lat=2 val=00001234", k, out_imm[0]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        chk_lat = 1'b0;
        out_ready[0] = 1'b0;
        send(0, 16'h0033, 2'd1);
        send(0, 16'h0044, 2'd1);
        rst[0] = 1'b1;
        @(posedge clk); #1;
        rst[0] = 1'b0;
        @(negedge clk);
        n_checks++;
        if (out_valid[0] !== 1'b0 || out_imm[0] !== 32'h0 || in_ready[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid got valid=%b imm=%h ready=%b expected 0/00000000/1",
                     out_valid[0], out_imm[0], in_ready[0]);
        end
        @(posedge clk); #1;
        out_ready[0] = 1'b1;
    endtask

    task automatic test_sweep();
        int d;
        int k;
        int base;
        chk_lat = 1'b1;
        for (int s = 0; s < 2; s++) begin
            d = s + 1;
            send(d, 16'hF00D, 2'd1);
            k = 0;
            for (int n = 1; n <= 10 && k == 0; n++) begin
                @(negedge clk);
                if (out_valid[d]) k = n;
            end
            n_checks++;
            if (k != depth_of(d) || out_imm[d] !== 32'hFFFFF00D) begin
                n_fail++;
                $display("FAIL sweep_single dut%0d got lat=%0d val=%h expected lat=%0d val=FFFFF00D",
                         d, k, out_imm[d], depth_of(d));
            end
            @(posedge clk); #1;
            base = out_cnt[d];
            for (int i = 0; i < 8; i++) begin
                in_valid[d] = 1'b1;
                in_imm[d]   = 16'(16'h1111 * (i + 1));
                in_mode[d]  = 2'(i);
                @(negedge clk);
                n_checks++;
                if (in_ready[d] !== 1'b1) begin
                    n_fail++; $display("FAIL sweep_rate dut%0d beat%0d got in_ready=%b expected 1", d, i, in_ready[d]);
                end
                @(posedge clk); #1;
            end
            in_valid[d] = 1'b0;
            repeat (depth_of(d)) @(negedge clk);
            #1;
            n_checks++;
            if (out_cnt[d] - base != 8) begin
                n_fail++; $display("FAIL sweep_count dut%0d got %0d expected 8", d, out_cnt[d] - base);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        mode_exp = '{32'h00008001, 32'hFFFF8001, 32'h80010000, 32'hFFFE0004};
        bnd_imm  = '{16'hFFFF, 16'h7FFF, 16'h0000};
        bnd_mode = '{2'd3, 2'd1, 2'd2};
        bnd_exp  = '{32'hFFFFFFFC, 32'h00007FFF, 32'h00000000};
        test_reset();
        test_modes();
        test_boundaries();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_sweep();
        repeat (10) @(posedge clk);
        #1;
        n_checks++;
        if (sbq.size() != 0) begin
            n_fail++; $display("FAIL sb_leftover got %0d entries expected 0", sbq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/imm_extend_pipe.md
# imm_extend_pipe

Parametrised, pipelined immediate-extension unit for the decode/execute boundary of the MIPS pipeline. It widens an IN_W-bit instruction immediate to OUT_W bits in one of four modes: zero-extend, sign-extend, upper-load and branch-offset. The result travels through DEPTH elastic register stages with valid/ready handshaking, flush and backpressure. It replaces the fixed 16-to-32 zero extender and the separate sign and shift logic.

## Interface
- IN_W, 16, immediate input width
- OUT_W, 32, extended output width; must satisfy OUT_W >= IN_W + 2
- DEPTH, 2, number of register stages, legal range 1..4
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  upstream offers an immediate
- in_ready  output  1  unit accepts an immediate this cycle
- in_imm  input  IN_W  raw immediate field
- in_mode  input  2  extension mode, captured with in_imm
- flush  input  1  discard all in-flight entries (branch mispredict or exception)
- out_valid  output  1  out_imm holds a valid result
- out_ready  input  1  downstream accepts the result
- out_imm  output  OUT_W  extended immediate

## Operation
- Extension is computed combinationally from in_imm and in_mode, then written into stage 0 on acceptance:
  - 00 zero: upper OUT_W-IN_W bits are 0.
  - 01 sign: upper bits replicate in_imm[IN_W-1].
  - 10 upper: in_imm << (OUT_W-IN_W), so the low bits are 0.
  - 11 branch: sign-extend, then shift left 2; the low 2 bits are 0.
- Stage storage:
  - Each stage k holds data_k[OUT_W] and valid_k.
  - Stage DEPTH-1 drives out_imm and out_valid.
- Stage k advances (loads from stage k-1, or from the input for k=0) when it is empty, or when its contents leave this cycle.
- Bubbles collapse: a valid entry moves into an empty downstream stage even when out_ready=0.
- Acceptance:
  - in_ready = !flush && (!valid_0 || stage 0 drains this cycle).
  - Transfer occurs on in_valid && in_ready.
- Output handshake:
  - Transfer occurs on out_valid && out_ready.
  - While out_valid && !out_ready, out_imm and out_valid hold unchanged.
- Flush:
  - On a cycle with flush=1, every valid_k clears at the next edge.
  - No input is accepted (in_ready=0).
  - An output handshake in that same cycle still counts as delivered to downstream.
  - Data registers are not cleared.
- Reset:
  - Every valid_k clears and every data_k is set to 0, so out_valid=0, out_imm=0, in_ready=0 during reset.
  - After reset deasserts, in_ready=1 on the first cycle.
  - Reset asserted mid-stream drops all entries, exactly like a flush, and has priority over flush and the handshakes.
- Precedence: reset > flush > normal advance.
- The entry count never exceeds DEPTH. When all stages are full and out_ready=0, in_ready=0.

## Timing
- Latency: an immediate accepted at edge N appears with out_valid=1 after edge N+DEPTH-1, i.e. DEPTH cycles including the capture cycle, provided no backpressure.
- Throughput: one result per cycle with out_ready held at 1; in_ready stays 1.
- Backpressure:
  - Deasserting out_ready for M cycles with a full pipe stalls input for M cycles.
  - When out_ready returns to 1, in_ready reasserts in the same cycle (combinational through the drain path).
- No combinational path from in_imm to out_imm; out_imm is always a register output.
- There is a combinational path from out_ready to in_ready.

## Test plan
- Mode check, DEPTH=2, in_imm=0x8001, out_ready=1:
  - Mode 00 gives 0x00008001.
  - Mode 01 gives 0xFFFF8001.
  - Mode 10 gives 0x80010000.
  - Mode 11 gives 0xFFFE0004.
  - Each appears 2 cycles after acceptance.
- Branch boundary values:
  - in_imm=0xFFFF, mode 11 gives 0xFFFFFFFC.
  - in_imm=0x7FFF, mode 01 gives 0x00007FFF.
  - in_imm=0x0000, mode 10 gives 0x00000000.
- Backpressure:
  - Stream 5 immediates 1..5 (mode 00) with out_ready=0 for cycles 3..6.
  - in_ready drops once 2 entries are held, and out_imm holds 0x00000001 stable.
  - After release, outputs arrive as 1,2,3,4,5 in order with no loss and no duplication.
- Flush:
  - With 2 valid entries in flight, pulse flush for 1 cycle.
  - The next cycle shows out_valid=0 and in_ready=1; an immediate presented during the flush cycle is not accepted.
  - The next accepted immediate emerges after DEPTH cycles.
- Reset mid-stream:
  - Assert reset for 1 cycle with the pipe full and out_ready=0.
  - Then out_valid=0, out_imm=0x00000000, and in_ready=1 on the following cycle.
- Parameter sweep: DEPTH=1 and DEPTH=4, IN_W=16, OUT_W=32; latency measures 1 and 4 cycles respectively, and full-rate throughput is maintained.
